trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have these ports: clk in 1 (clock); rst in 1 (reset, asynchronous, active-high).
REQ-002 The block SHALL have these event inputs: exc_valid in 1 (commit-stage exception); exc_code in 5 (exception cause code); exc_pc in 32 (faulting PC); exc_tval in 32 (fault value).
REQ-003 The block SHALL have these return and interrupt inputs: mret_req in 1; sret_req in 1; int_pc in 32 (PC of next uncommitted instruction); timer_interrupt in 1.
REQ-004 The block SHALL have these CSR-state inputs: mie_mtie in 1; mstatus_mie in 1; priv_mode in 2; mtvec in 32; mepc in 32; sepc in 32; pipe_idle in 1 (no outstanding memory access).
REQ-005 The block SHALL have these CSR-side outputs: trap_enter out 1; trap_cause out 32; trap_pc out 32; trap_val out 32; mret_exec out 1; sret_exec out 1.
REQ-006 The block SHALL have these pipeline-side outputs: flush out 1; redirect_valid out 1; redirect_pc out 32; busy out 1.

Function
REQ-007 The FSM SHALL have exactly four states: IDLE, DRAIN, COMMIT, REDIRECT.
REQ-008 In IDLE, the block SHALL select one event per cycle with priority exc_valid > interrupt > mret_req > sret_req, and latch kind, cause, pc and val.
REQ-009 An interrupt SHALL be taken when timer_interrupt && mie_mtie && (mstatus_mie || priv_mode != 2'b11).
REQ-010 For an interrupt, the block SHALL latch cause 32'h8000_0007, pc = int_pc and val = 0.
REQ-011 For an exception, the block SHALL latch cause = {27'b0, exc_code}, pc = exc_pc and val = exc_tval.
REQ-012 From IDLE with an event selected, the FSM SHALL go to COMMIT if pipe_idle=1, else to DRAIN.
REQ-013 DRAIN SHALL hold until pipe_idle=1, then go to COMMIT.
REQ-014 In COMMIT, the block SHALL pulse exactly one of trap_enter, mret_exec or sret_exec for one cycle, with trap_cause, trap_pc and trap_val driven from the latches.
REQ-015 COMMIT SHALL go to REDIRECT unconditionally.
REQ-016 In REDIRECT, redirect_valid SHALL be 1 for one cycle, and the FSM SHALL return to IDLE.
REQ-017 redirect_pc SHALL be {mtvec[31:2],2'b00} for a trap, mepc for mret, and sepc for sret.
REQ-018 redirect_pc SHALL be sampled in the COMMIT cycle, so that an mepc/mtvec update caused by the same commit is not used.
REQ-019 flush and busy SHALL equal (state != IDLE).
REQ-020 Events arriving while the FSM is not in IDLE SHALL be ignored and not queued.
REQ-021 An event with pipe_idle=1 detected at cycle N SHALL produce the commit pulse at N+1 and redirect_valid at N+2.
REQ-022 Simultaneous exc_valid and mret_req SHALL result in the exception only, with mret_exec held at 0.
REQ-023 trap_cause, trap_pc and trap_val SHALL hold their last latched values outside COMMIT.

Reset
REQ-024 On rst, the FSM SHALL go to IDLE, all 1-bit outputs SHALL go to 0, all 32-bit outputs and latches SHALL go to 0, and any in-flight event SHALL be discarded.
REQ-025 Release of rst SHALL take effect on the first clk edge after deassertion.

Configuration
REQ-026 Macro TRAP_VECTORED_EN, when defined, SHALL set redirect_pc for an interrupt to {mtvec[31:2],2'b00} + 4*cause[4:0] whenever mtvec[1:0]==2'b01; exceptions SHALL always use the base address.
REQ-027 When TRAP_VECTORED_EN is undefined, mtvec[1:0] SHALL be ignored and all traps SHALL use the base address.

Verification
REQ-028 Scenario: pipe_idle=1, exc_valid=1, exc_code=2, exc_pc=32'h100, mtvec=32'h200 -> trap_enter at N+1 with cause 32'h2 and pc 32'h100; redirect_valid at N+2 with redirect_pc 32'h200.
REQ-029 Scenario: timer_interrupt=1, mie_mtie=1, mstatus_mie=0, priv_mode=3 -> no trap; then priv_mode=0 -> trap_enter with cause 32'h8000_0007 and trap_pc=int_pc.
REQ-030 Scenario: mret_req with pipe_idle=0 for 3 cycles, mepc=32'h80 -> FSM in DRAIN for 3 cycles with flush=1, mret_exec once, then redirect_pc 32'h80.
REQ-031 Scenario: exc_valid and mret_req in the same cycle -> trap_enter=1, mret_exec stays 0.
REQ-032 Scenario: rst asserted in DRAIN -> immediately busy=0, flush=0, no later commit pulse.
REQ-033 Scenario: with TRAP_VECTORED_EN defined, mtvec=32'h301, timer interrupt -> redirect_pc 32'h31C; with it undefined -> redirect_pc 32'h300.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-time trap/return sequencer (drain, commit, redirect).
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==01.
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  input  logic        sret_req,
  input  logic [31:0] int_pc,
  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [1:0]  priv_mode,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] sepc,
  input  logic        pipe_idle,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        sret_exec,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE, DRAIN, COMMIT, REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_TRAP, K_MRET, K_SRET
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, sel_kind;
  logic [31:0] cause_q, pc_q, val_q;
  logic [31:0] sel_cause, sel_pc, sel_val;
  logic [31:0] tgt_pc, base_pc;
  logic        irq, ev;

  assign irq = timer_interrupt & mie_mtie
             & (mstatus_mie | (priv_mode != 2'b11));
  assign ev  = exc_valid | irq | mret_req | sret_req;

  // Priority select of the single event taken this cycle.
  always_comb begin
    sel_kind  = K_TRAP;
    sel_cause = '0;
    sel_pc    = '0;
    sel_val   = '0;
    if (exc_valid) begin
      sel_cause = {27'b0, exc_code};
      sel_pc    = exc_pc;
      sel_val   = exc_tval;
    end else if (irq) begin
      sel_cause = 32'h8000_0007;
      sel_pc    = int_pc;
    end else if (mret_req) begin
      sel_kind = K_MRET;
    end else if (sret_req) begin
      sel_kind = K_SRET;
    end
  end

  // Next-state logic; events outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ev) state_d = pipe_idle ? COMMIT : DRAIN;
      DRAIN:    if (pipe_idle) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
    endcase
  end

  assign base_pc = {mtvec[31:2], 2'b00};

  // Redirect target from the latched event kind and current CSRs.
  always_comb begin
    tgt_pc = base_pc;
    unique case (kind_q)
      K_MRET:  tgt_pc = mepc;
      K_SRET:  tgt_pc = sepc;
      default: begin
`ifdef TRAP_VECTORED_EN
        if (cause_q[31] && mtvec[1:0] == 2'b01)
          tgt_pc = base_pc + {25'b0, cause_q[4:0], 2'b00};
`endif
      end
    endcase
  end

`ifndef TRAP_VECTORED_EN
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Event latches, captured only when an event is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q  <= K_TRAP;
      cause_q <= '0;
      pc_q    <= '0;
      val_q   <= '0;
    end else if (state_q == IDLE && ev) begin
      kind_q  <= sel_kind;
      cause_q <= sel_cause;
      pc_q    <= sel_pc;
      val_q   <= sel_val;
    end
  end

  // Target is sampled in COMMIT so a same-commit CSR write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    redirect_pc <= '0;
    else if (state_q == COMMIT) redirect_pc <= tgt_pc;
  end

  assign trap_enter = (state_q == COMMIT) && (kind_q == K_TRAP);
  assign mret_exec  = (state_q == COMMIT) && (kind_q == K_MRET);
  assign sret_exec  = (state_q == COMMIT) && (kind_q == K_SRET);
  assign trap_cause = cause_q;
  assign trap_pc    = pc_q;
  assign trap_val   = val_q;

  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q != IDLE);
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed checks of trap_ctrl sequencing and targets.
// Expected vectored target depends on TRAP_VECTORED_EN.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        mret_req = 1'b0;
  logic        sret_req = 1'b0;
  logic [31:0] int_pc = '0;
  logic        timer_interrupt = 1'b0;
  logic        mie_mtie = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic [1:0]  priv_mode = 2'b11;
  logic [31:0] mtvec = 32'h200;
  logic [31:0] mepc = '0;
  logic [31:0] sepc = '0;
  logic        pipe_idle = 1'b1;
  logic        trap_enter;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret_exec;
  logic        sret_exec;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int errs = 0;
  int checks = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .sret_req(sret_req),
    .int_pc(int_pc), .timer_interrupt(timer_interrupt),
    .mie_mtie(mie_mtie), .mstatus_mie(mstatus_mie),
    .priv_mode(priv_mode), .mtvec(mtvec),
    .mepc(mepc), .sepc(sepc), .pipe_idle(pipe_idle),
    .trap_enter(trap_enter), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val),
    .mret_exec(mret_exec), .sret_exec(sret_exec),
    .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_rpc", redirect_pc, 32'h0);
    check("rst_cause", trap_cause, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Exception, pipe idle: commit at N+1, redirect at N+2.
    exc_valid = 1'b1; exc_code = 5'd2;
    exc_pc = 32'h100; exc_tval = 32'h55;
    tick();
    exc_valid = 1'b0;
    check("exc_enter", 32'(trap_enter), 32'd1);
    check("exc_cause", trap_cause, 32'h2);
    check("exc_pc", trap_pc, 32'h100);
    check("exc_val", trap_val, 32'h55);
    check("exc_rv0", 32'(redirect_valid), 32'd0);
    check("exc_busy", 32'(busy), 32'd1);
    tick();
    check("exc_rv", 32'(redirect_valid), 32'd1);
    check("exc_rpc", redirect_pc, 32'h200);
    check("exc_enter0", 32'(trap_enter), 32'd0);
    tick();
    check("exc_done", 32'(busy), 32'd0);
    check("exc_hold", trap_cause, 32'h2);

    // Interrupt masked in M-mode with mstatus.MIE=0.
    timer_interrupt = 1'b1; mie_mtie = 1'b1;
    mstatus_mie = 1'b0; priv_mode = 2'b11;
    int_pc = 32'h444;
    tick();
    check("irq_mask", 32'(busy), 32'd0);
    tick();
    check("irq_mask2", 32'(trap_enter), 32'd0);
    priv_mode = 2'b00;
    tick();
    timer_interrupt = 1'b0;
    check("irq_enter", 32'(trap_enter), 32'd1);
    check("irq_cause", trap_cause, 32'h8000_0007);
    check("irq_pc", trap_pc, 32'h444);
    check("irq_val", trap_val, 32'h0);
    tick();
    check("irq_rpc", redirect_pc, 32'h200);
    tick();

    // mret with pipeline busy for three drain cycles.
    mepc = 32'h80; pipe_idle = 1'b0; mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_flush", 32'(flush), 32'd1);
      check("drain_mret0", 32'(mret_exec), 32'd0);
      if (i == 2) pipe_idle = 1'b1;
      tick();
    end
    check("mret_exec", 32'(mret_exec), 32'd1);
    check("mret_trap0", 32'(trap_enter), 32'd0);
    tick();
    mepc = 32'h999;
    #1;
    check("mret_rv", 32'(redirect_valid), 32'd1);
    check("mret_rpc", redirect_pc, 32'h80);
    check("mret_once", 32'(mret_exec), 32'd0);
    tick();

    // sret targets sepc.
    sepc = 32'h1234; sret_req = 1'b1;
    tick();
    sret_req = 1'b0;
    check("sret_exec", 32'(sret_exec), 32'd1);
    tick();
    check("sret_rpc", redirect_pc, 32'h1234);
    tick();

    // Exception and mret together: exception wins.
    exc_valid = 1'b1; mret_req = 1'b1; exc_code = 5'd5;
    tick();
    exc_valid = 1'b0; mret_req = 1'b0;
    check("both_enter", 32'(trap_enter), 32'd1);
    check("both_mret0", 32'(mret_exec), 32'd0);
    check("both_cause", trap_cause, 32'h5);
    tick();
    check("both_rpc", redirect_pc, 32'h200);
    tick();

    // Event arriving during DRAIN is dropped.
    exc_valid = 1'b1; exc_code = 5'd4; pipe_idle = 1'b0;
    tick();
    exc_valid = 1'b0; sret_req = 1'b1;
    tick();
    pipe_idle = 1'b1;
    tick();
    sret_req = 1'b0;
    check("drop_enter", 32'(trap_enter), 32'd1);
    check("drop_sret0", 32'(sret_exec), 32'd0);
    check("drop_cause", trap_cause, 32'h4);
    tick();
    tick();
    check("drop_idle", 32'(busy), 32'd0);
    tick();
    check("drop_noq", 32'(busy), 32'd0);

    // Reset during DRAIN aborts the event.
    exc_valid = 1'b1; exc_code = 5'd7; pipe_idle = 1'b0;
    tick();
    exc_valid = 1'b0;
    check("rd_busy1", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rd_busy0", 32'(busy), 32'd0);
    check("rd_flush0", 32'(flush), 32'd0);
    check("rd_cause0", trap_cause, 32'h0);
    check("rd_rpc0", redirect_pc, 32'h0);
    tick();
    rst = 1'b0; pipe_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_noenter", 32'(trap_enter), 32'd0);
      check("rd_noflush", 32'(flush), 32'd0);
    end

    // Vectored mode: interrupt may use vector, exception never does.
    mtvec = 32'h301; timer_interrupt = 1'b1;
    mstatus_mie = 1'b1; priv_mode = 2'b11;
    tick();
    timer_interrupt = 1'b0;
    check("vec_enter", 32'(trap_enter), 32'd1);
    tick();
`ifdef TRAP_VECTORED_EN
    check("vec_rpc", redirect_pc, 32'h31C);
`else
    check("vec_rpc", redirect_pc, 32'h300);
`endif
    tick();
    exc_valid = 1'b1; exc_code = 5'd3;
    tick();
    exc_valid = 1'b0;
    tick();
    check("vec_exc_rpc", redirect_pc, 32'h300);
    tick();
    check("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
